// File: rtl/axi_mm_fifo_sched.sv
// Write-path scheduler for the AXI memory-mapped FIFO: launches ring-buffer block writes
// on fill threshold, idle timeout or flush, and tracks written-but-unconsumed blocks.
module axi_mm_fifo_sched #(
    parameter int unsigned C_WIDTH         = 64,
    parameter int unsigned C_START_ADDR    = 0,
    parameter int unsigned C_END_ADDR      = 134217727,
    parameter int unsigned C_AVAIL_WIDTH   = 16,
    parameter int unsigned C_TIMEOUT_WIDTH = 32,
    localparam int unsigned BS             = C_WIDTH * (C_WIDTH / 8),
    localparam int unsigned C_BLOCKS       = C_END_ADDR / BS - C_START_ADDR / BS + 1,
    localparam int unsigned OCC_W          = $clog2(C_BLOCKS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic                       flush,
    input  logic [C_AVAIL_WIDTH-1:0]   threshold,
    input  logic [C_TIMEOUT_WIDTH-1:0] timeout,
    input  logic [C_AVAIL_WIDTH-1:0]   values_available,
    input  logic                       rd_ack,
    output logic                       s2mm_enable,
    input  logic                       s2mm_busy,
    output logic [OCC_W-1:0]           occupancy,
    output logic                       full,
    output logic                       irq,
    output logic [31:0]                blocks_written,
    output logic                       ack_error,
    output logic                       idle
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_LAUNCH = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    localparam int unsigned                PAYLOAD   = C_WIDTH - 2;
    localparam logic [C_AVAIL_WIDTH-1:0]   ETH_MAX   = C_AVAIL_WIDTH'(PAYLOAD);
    localparam logic [C_TIMEOUT_WIDTH-1:0] TIMER_MAX = '1;
    localparam logic [OCC_W-1:0]           OCC_FULL  = OCC_W'(C_BLOCKS);

    logic [1:0]                 state_q, state_d;
    logic [C_TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic                       flush_pend_q, flush_pend_d;
    logic [OCC_W-1:0]           occ_q, occ_d;
    logic                       full_q, full_d;
    logic                       irq_q, irq_d;
    logic [31:0]                blocks_q, blocks_d;
    logic                       ack_error_q, ack_error_d;
    logic                       enable_q, enable_d;

    logic [C_AVAIL_WIDTH-1:0]   eth;
    logic                       has_data;
    logic                       timed_out;
    logic                       trigger;
    logic                       completion;

    // Threshold clamped to [1, payload] so a block is never launched empty or overfilled.
    always_comb begin
        eth = threshold;
        if (threshold == '0) begin
            eth = C_AVAIL_WIDTH'(1);
        end
        if (eth > ETH_MAX) begin
            eth = ETH_MAX;
        end
    end

    assign has_data   = (values_available != '0);
    assign timed_out  = (timeout != '0) && (timer_q >= timeout);
    assign trigger    = run && !full_q && has_data &&
                        ((values_available >= eth) || flush_pend_q || timed_out);
    assign completion = (state_q == S_RUN) && !s2mm_busy;

    always_comb begin
        state_d      = state_q;
        timer_d      = '0;
        flush_pend_d = flush_pend_q | flush;
        occ_d        = occ_q;
        ack_error_d  = ack_error_q;
        blocks_d     = blocks_q + 32'(completion);
        irq_d        = completion;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (trigger) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (s2mm_busy) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!s2mm_busy) begin
                    state_d = run ? S_ARMED : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timer only runs while waiting in ARMED with data present.
        if ((state_q == S_ARMED) && (state_d == S_ARMED) && has_data) begin
            timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + C_TIMEOUT_WIDTH'(1);
        end

        // A flush arriving with the launch is absorbed by that launch.
        if ((state_q == S_IDLE) || (state_d == S_IDLE) ||
            ((state_q == S_ARMED) && (state_d == S_LAUNCH))) begin
            flush_pend_d = 1'b0;
        end

        if (completion && !rd_ack) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!completion && rd_ack) begin
            if (occ_q == '0) begin
                ack_error_d = 1'b1;
            end else begin
                occ_d = occ_q - OCC_W'(1);
            end
        end

        full_d   = (occ_d == OCC_FULL);
        enable_d = (state_d == S_LAUNCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            flush_pend_q <= 1'b0;
            occ_q        <= '0;
            full_q       <= 1'b0;
            irq_q        <= 1'b0;
            blocks_q     <= '0;
            ack_error_q  <= 1'b0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            flush_pend_q <= flush_pend_d;
            occ_q        <= occ_d;
            full_q       <= full_d;
            irq_q        <= irq_d;
            blocks_q     <= blocks_d;
            ack_error_q  <= ack_error_d;
            enable_q     <= enable_d;
        end
    end

    assign s2mm_enable    = enable_q;
    assign occupancy      = occ_q;
    assign full           = full_q;
    assign irq            = irq_q;
    assign blocks_written = blocks_q;
    assign ack_error      = ack_error_q;
    assign idle           = (state_q == S_IDLE) && !s2mm_busy;

endmodule

// File: tb/tb_axi_mm_fifo_sched.sv
// Scoreboard bench for axi_mm_fifo_sched: 8-bit data, 32-byte ring (6 values/block, 4 blocks).
`timescale 1ns/1ps
module tb_axi_mm_fifo_sched;

    localparam int unsigned AW = 16;
    localparam int unsigned TW = 32;

    typedef struct {
        int occ;
        int bw;
        int full;
    } cmpl_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          flush = 1'b0;
    logic          rd_ack = 1'b0;
    logic          s2mm_busy = 1'b0;
    logic [AW-1:0] threshold = AW'(6);
    logic [AW-1:0] values_available = '0;
    logic [TW-1:0] timeout = '0;
    logic          s2mm_enable;
    logic [2:0]    occupancy;
    logic          full;
    logic          irq;
    logic [31:0]   blocks_written;
    logic          ack_error;
    logic          idle;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    launch_q[$];
    cmpl_t cmpl_q[$];

    axi_mm_fifo_sched #(
        .C_WIDTH(8),
        .C_START_ADDR(0),
        .C_END_ADDR(31),
        .C_AVAIL_WIDTH(AW),
        .C_TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .flush(flush),
        .threshold(threshold),
        .timeout(timeout),
        .values_available(values_available),
        .rd_ack(rd_ack),
        .s2mm_enable(s2mm_enable),
        .s2mm_busy(s2mm_busy),
        .occupancy(occupancy),
        .full(full),
        .irq(irq),
        .blocks_written(blocks_written),
        .ack_error(ack_error),
        .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_launch(input int c);
        launch_q.push_back(c);
    endtask

    task automatic exp_cmpl(input int o, input int b, input int f);
        cmpl_t e;
        e.occ = o;
        e.bw = b;
        e.full = f;
        cmpl_q.push_back(e);
    endtask

    // Engine model: busy rises the cycle after it first sees enable, holds 4 cycles.
    initial begin : engine
        bit pend;
        int cnt;
        pend = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s2mm_busy = 1'b0;
                pend = 1'b0;
                cnt = 0;
            end else if (s2mm_busy) begin
                if (cnt == 0) s2mm_busy = 1'b0;
                else cnt--;
            end else if (pend) begin
                s2mm_busy = 1'b1;
                cnt = 3;
                pend = 1'b0;
            end else if (s2mm_enable) begin
                pend = 1'b1;
            end
        end
    end

    // Monitor: pops expected launches on enable rise and expected counters on irq.
    initial begin : monitor
        bit    en_prev;
        int    en_len;
        int    exp_cyc;
        cmpl_t e;
        en_prev = 1'b0;
        en_len = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                en_prev = 1'b0;
                en_len = 0;
            end else begin
                if (s2mm_enable) begin
                    if (!en_prev) begin
                        if (launch_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_launch: enable rose at cycle %0d, none queued", cyc);
                        end else begin
                            exp_cyc = launch_q.pop_front();
                            check("launch_cycle", cyc, exp_cyc);
                        end
                    end
                    en_len++;
                end else if (en_prev) begin
                    check("enable_width", en_len, 2);
                    en_len = 0;
                end
                if (irq) begin
                    if (cmpl_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_irq: irq at cycle %0d, none queued", cyc);
                    end else begin
                        e = cmpl_q.pop_front();
                        check("cmpl_occupancy", occupancy, e.occ);
                        check("cmpl_blocks_written", blocks_written, e.bw);
                        check("cmpl_full", full, e.full);
                    end
                end
                en_prev = s2mm_enable;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t;
        tick(2);
        #1;
        check("rst_enable", s2mm_enable, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_blocks_written", blocks_written, 0);
        check("rst_full", full, 0);
        check("rst_irq", irq, 0);
        check("rst_ack_error", ack_error, 0);
        check("rst_idle", idle, 1);
        rst_n = 1'b1;
        tick(1);
        run = 1'b1;
        tick(3);

        // Threshold launch
        t = cyc;
        values_available = AW'(6);
        exp_launch(t + 1);
        exp_cmpl(1, 1, 0);
        tick(1);
        values_available = '0;
        tick(10);

        // Timeout launch
        t = cyc;
        timeout = TW'(10);
        values_available = AW'(2);
        exp_launch(t + 11);
        exp_cmpl(2, 2, 0);
        tick(12);
        values_available = '0;
        tick(10);

        // Timeout disabled: no launch
        timeout = '0;
        values_available = AW'(2);
        tick(1000);
        check("no_timeout_occupancy", occupancy, 2);
        check("no_timeout_blocks", blocks_written, 2);
        values_available = '0;
        tick(2);

        // Flush with a single value; pending flush consumed by the launch
        t = cyc;
        values_available = AW'(1);
        flush = 1'b1;
        exp_launch(t + 2);
        exp_cmpl(3, 3, 0);
        tick(1);
        flush = 1'b0;
        tick(30);
        values_available = '0;
        tick(2);

        // Drain with rd_ack
        for (int i = 0; i < 3; i++) begin
            rd_ack = 1'b1;
            tick(1);
            rd_ack = 1'b0;
            check("rd_ack_occupancy", occupancy, 2 - i);
        end

        // Underflow
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        check("underflow_ack_error", ack_error, 1);
        check("underflow_occupancy", occupancy, 0);
        tick(1);

        // Threshold 0 clamps to 1
        t = cyc;
        threshold = '0;
        values_available = AW'(1);
        exp_launch(t + 1);
        exp_cmpl(1, 4, 0);
        tick(1);
        values_available = '0;
        tick(10);

        // Threshold 100 clamps to 6
        threshold = AW'(100);
        values_available = AW'(5);
        tick(20);
        check("clamp_hi_no_launch", occupancy, 1);
        t = cyc;
        values_available = AW'(6);
        exp_launch(t + 1);
        exp_cmpl(2, 5, 0);
        tick(1);
        values_available = '0;
        tick(10);

        // Fill the ring with back-to-back launches
        threshold = AW'(6);
        t = cyc;
        values_available = AW'(6);
        exp_launch(t + 1);
        exp_cmpl(3, 6, 0);
        exp_launch(t + 8);
        exp_cmpl(4, 7, 1);
        tick(30);
        check("ring_full", full, 1);
        check("ring_full_occupancy", occupancy, 4);
        check("ring_full_enable", s2mm_enable, 0);

        // One rd_ack reopens the ring; a second coincides with the completion
        t = cyc;
        rd_ack = 1'b1;
        exp_launch(t + 2);
        exp_cmpl(3, 8, 0);
        exp_launch(t + 9);
        exp_cmpl(4, 9, 1);
        tick(1);
        rd_ack = 1'b0;
        check("ack_release_occupancy", occupancy, 3);
        tick(6);
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        tick(22);

        // Drop run mid-block: block completes, then idle
        t = cyc;
        rd_ack = 1'b1;
        exp_launch(t + 2);
        exp_cmpl(4, 10, 1);
        tick(1);
        rd_ack = 1'b0;
        tick(3);
        run = 1'b0;
        tick(6);
        #1;
        check("stop_idle", idle, 1);
        check("stop_blocks_written", blocks_written, 10);

        // Reset asserted while in LAUNCH
        tick(1);
        t = cyc;
        rd_ack = 1'b1;
        run = 1'b1;
        exp_launch(t + 2);
        tick(1);
        rd_ack = 1'b0;
        tick(1);
        #1;
        check("pre_reset_enable", s2mm_enable, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_enable", s2mm_enable, 0);
        check("mid_rst_occupancy", occupancy, 0);
        check("mid_rst_blocks_written", blocks_written, 0);
        check("mid_rst_full", full, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_ack_error", ack_error, 0);
        tick(2);
        #1;
        check("mid_rst_idle", idle, 1);
        run = 1'b0;
        values_available = '0;
        rst_n = 1'b1;
        tick(3);

        check("launch_queue_drained", launch_q.size(), 0);
        check("cmpl_queue_drained", cmpl_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_mm_fifo_sched.md
# axi_mm_fifo_sched

Scheduling controller for the AXI memory-mapped FIFO write path. It decides when the stream-to-memory engine writes its next ring-buffer block, based on FIFO fill threshold, idle timeout or explicit flush. It tracks how many written blocks the host has not yet consumed and stalls writes when the ring is full. It sits between the engine's `enable`/`busy` handshake, the stream FIFO occupancy count and the host register file.

## Interface
Parameters:
- `C_WIDTH`, 64: data width in bits. Block size BS = C_WIDTH*(C_WIDTH/8) bytes; payload = C_WIDTH-2 values per block.
- `C_START_ADDR`, 0: first byte of the ring.
- `C_END_ADDR`, 134217727: last byte of the ring.
- `C_AVAIL_WIDTH`, 16: width of the FIFO occupancy count.
- `C_TIMEOUT_WIDTH`, 32: width of the timeout setting.
- Derived: C_BLOCKS = C_END_ADDR/BS - C_START_ADDR/BS + 1 (integer division); OCC_W = $clog2(C_BLOCKS+1).

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `run`  in  1  level; allow new block launches.
- `flush`  in  1  pulse; force a partial block as soon as data exists.
- `threshold`  in  C_AVAIL_WIDTH  fill level that triggers a launch.
- `timeout`  in  C_TIMEOUT_WIDTH  idle cycles before a partial launch; 0 disables the timeout.
- `values_available`  in  C_AVAIL_WIDTH  stream FIFO occupancy.
- `rd_ack`  in  1  pulse; host consumed one block.
- `s2mm_enable`  out  1  launch request to the engine.
- `s2mm_busy`  in  1  engine busy.
- `occupancy`  out  OCC_W  written, unconsumed blocks.
- `full`  out  1  occupancy == C_BLOCKS.
- `irq`  out  1  one-cycle pulse per completed block.
- `blocks_written`  out  32  wrapping count of completed blocks.
- `ack_error`  out  1  sticky; `rd_ack` arrived with occupancy 0.
- `idle`  out  1  state IDLE and `s2mm_busy` = 0.

## Operation
- States:
  - IDLE: wait for `run`. Exit to ARMED when `run` = 1.
  - ARMED: evaluate the trigger. Exit to LAUNCH when the trigger holds. Exit to IDLE when `run` = 0.
  - LAUNCH: hold `s2mm_enable` high. Exit to RUN when `s2mm_busy` = 1.
  - RUN: wait for the engine to finish. When `s2mm_busy` = 0, exit to ARMED if `run` = 1, else to IDLE.
- Completion event = RUN with `s2mm_busy` = 0. On a completion event:
  - `occupancy` +1;
  - `blocks_written` +1, wrapping modulo 2^32;
  - `irq` pulses.
- `s2mm_enable` = (state == LAUNCH), decoded from the state register.
- Effective threshold: eth = min(max(`threshold`,1), C_WIDTH-2).
- Trigger in ARMED requires all of:
  - `run` = 1;
  - `full` = 0;
  - `values_available` != 0;
  - at least one of: `values_available` >= eth; `flush_pend` = 1; (`timeout` != 0 and timer >= `timeout`).
- Timer (C_TIMEOUT_WIDTH bits, saturating):
  - counts +1 per cycle in ARMED while `values_available` != 0;
  - clears to 0 when `values_available` == 0, on leaving ARMED, and in IDLE.
- `flush_pend`:
  - set by `flush` in any state;
  - cleared on entry to LAUNCH and in IDLE;
  - a `flush` in the same cycle as entry to LAUNCH is consumed by that launch.
- Occupancy arithmetic:
  - completion and `rd_ack` in the same cycle: unchanged;
  - `rd_ack` alone at 0: `occupancy` unchanged, `ack_error` set;
  - `ack_error` clears only on reset.
- Dropping `run` in LAUNCH or RUN never aborts the block. The controller finishes the block, then goes to IDLE.
- Deasserting `run` in ARMED goes to IDLE even if `flush_pend` = 1; the pending flush is dropped.

## Timing
- Reset values: state IDLE; all outputs 0 (`idle` = 1 if `s2mm_busy` = 0); timer, `flush_pend` and `ack_error` 0.
- Launch latency: trigger true at cycle t → `s2mm_enable` = 1 at t+1.
- The engine raises `s2mm_busy` at t+2. The controller enters RUN at t+3, so `s2mm_enable` is high for exactly 2 cycles.
- `s2mm_busy` low first sampled in RUN at cycle c. At c+1:
  - `occupancy`, `blocks_written` and `full` are updated;
  - `irq` = 1 for one cycle;
  - state is ARMED (or IDLE).
- Earliest next launch: trigger at c+1, `s2mm_enable` at c+2.
- `full` is registered alongside `occupancy`. A full ring blocks the trigger from the cycle after the completion.
- `rd_ack` at cycle a → `occupancy` updated at a+1. A launch can occur with the trigger evaluated at a+1, so `s2mm_enable` = 1 at a+2.
- Timeout: `values_available` goes 0→k with k < eth at cycle s in ARMED (timer 0 at s). With `timeout` = T, the timer first reaches T at s+T, so `s2mm_enable` = 1 at s+T+1.
- Asserting `rst_n` low mid-block forces IDLE and clears all counters immediately (asynchronously). The engine is reset by the same net.

## Test plan
All scenarios use C_WIDTH=8, C_START_ADDR=0, C_END_ADDR=31, giving 6 values per block and C_BLOCKS=4.
- Threshold launch: `threshold`=6, `timeout`=0; raise `values_available` to 6 at cycle t → `s2mm_enable` high at t+1 and t+2. After the engine model finishes: `occupancy`=1, `blocks_written`=1, one `irq` pulse.
- Timeout: `threshold`=6, `timeout`=10, `values_available`=2 from cycle s → `s2mm_enable` rises at s+11, not earlier. Repeat with `timeout`=0 → no launch within 1000 cycles.
- Flush and clamp: `values_available`=1, pulse `flush` → launch. `threshold`=0 with `values_available`=1 → launch (eth=1). `threshold`=100 with `values_available`=6 → launch (eth=6).
- Ring full: run 4 blocks with no `rd_ack` → `full`=1, `occupancy`=4, no 5th launch. A single `rd_ack` → `occupancy`=3 and `s2mm_enable` two cycles later. `rd_ack` coincident with a completion leaves `occupancy` unchanged.
- Underflow: `rd_ack` at `occupancy`=0 → `ack_error`=1 and `occupancy` stays 0.
- Stop and reset: drop `run` during RUN → the block completes (`blocks_written`+1), then `idle`=1. Assert `rst_n` low mid-LAUNCH → `s2mm_enable` drops immediately and all counters read 0.
